// File: rtl/bcd_countdown_timer.sv
// Minutes:seconds BCD countdown timer feeding the 4-digit seven-segment display driver.
// Operator loads a start time, starts/pauses/resumes it; done pulses once on reaching 00:00.
module bcd_countdown_timer #(
    parameter int DIV = 100000000,
    parameter int PW  = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  set_mins,
    input  logic [7:0]  set_secs,
    output logic [11:0] mins,
    output logic [11:0] secs,
    output logic        running,
    output logic        done,
    output logic        expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    mins_q, mins_d;
    logic [7:0]    secs_q, secs_d;
    logic          done_q, done_d;

    logic [7:0]    mins_dec, secs_dec;
    logic          dec_zero;
    logic          tick;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    assign tick = (presc_q == PW'(DIV - 1));

    // One-second BCD decrement with borrow across both digit pairs.
    always_comb begin
        mins_dec = mins_q;
        secs_dec = secs_q;
        if (secs_q[3:0] != 4'd0) begin
            secs_dec = {secs_q[7:4], secs_q[3:0] - 4'd1};
        end else if (secs_q[7:4] != 4'd0) begin
            secs_dec = {secs_q[7:4] - 4'd1, 4'd9};
        end else if (mins_q != 8'h00) begin
            secs_dec = 8'h59;
            if (mins_q[3:0] != 4'd0) begin
                mins_dec = {mins_q[7:4], mins_q[3:0] - 4'd1};
            end else begin
                mins_dec = {mins_q[7:4] - 4'd1, 4'd9};
            end
        end
        dec_zero = (mins_dec == 8'h00) && (secs_dec == 8'h00);
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            presc_d = '0;
            mins_d  = {clamp_digit(set_mins[7:4], 4'd9), clamp_digit(set_mins[3:0], 4'd9)};
            secs_d  = {clamp_digit(set_secs[7:4], 4'd5), clamp_digit(set_secs[3:0], 4'd9)};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        presc_d = '0;
                        if (mins_q == 8'h00 && secs_q == 8'h00) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                        mins_d  = mins_dec;
                        secs_d  = secs_dec;
                        if (dec_zero) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = EXPIRED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            mins_q  <= 8'h00;
            secs_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            mins_q  <= mins_d;
            secs_q  <= secs_d;
            done_q  <= done_d;
        end
    end

    assign mins    = {4'h0, mins_q};
    assign secs    = {4'h0, secs_q};
    assign running = (state_q == RUN);
    assign expired = (state_q == EXPIRED);
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with DIV=4: vector table plus multi-cycle sequences.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst, load, start, stop;
    logic [7:0]  set_mins, set_secs;
    logic [11:0] mins, secs;
    logic        running, done, expired;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_countdown_timer #(.DIV(4), .PW(3)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start), .stop(stop),
        .set_mins(set_mins), .set_secs(set_secs),
        .mins(mins), .secs(secs), .running(running), .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st, sp;
        logic [7:0]  smin, ssec;
        logic [11:0] emin, esec;
        logic        erun, edone, eexp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic ld, input logic st, input logic sp,
                               input logic [7:0] smin, input logic [7:0] ssec,
                               input logic [11:0] emin, input logic [11:0] esec,
                               input logic erun, input logic edone, input logic eexp);
        vec_t r;
        r = '{ld, st, sp, smin, ssec, emin, esec, erun, edone, eexp};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic step(input logic ld, input logic st, input logic sp,
                        input logic [7:0] sm, input logic [7:0] ss);
        rst = 1'b0; load = ld; start = st; stop = sp; set_mins = sm; set_secs = ss;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic chk_all(input string nm, input logic [11:0] em, input logic [11:0] es,
                           input logic er, input logic ed, input logic ex);
        chk({nm, "_mins"}, 32'(mins), 32'(em));
        chk({nm, "_secs"}, 32'(secs), 32'(es));
        chk({nm, "_running"}, 32'(running), 32'(er));
        chk({nm, "_done"}, 32'(done), 32'(ed));
        chk({nm, "_expired"}, 32'(expired), 32'(ex));
    endtask

    initial begin
        int cyc;
        bit seen;

        // Clamp and zero-start expiry.
        vecs.push_back(v(1,0,0, 8'h9F,8'hAB, 12'h099,12'h059, 0,0,0));
        vecs.push_back(v(1,0,0, 8'h00,8'h00, 12'h000,12'h000, 0,0,0));
        vecs.push_back(v(0,1,0, 8'h00,8'h00, 12'h000,12'h000, 0,1,1));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h000,12'h000, 0,0,1));
        vecs.push_back(v(0,1,0, 8'h00,8'h00, 12'h000,12'h000, 0,0,1));
        vecs.push_back(v(0,0,1, 8'h00,8'h00, 12'h000,12'h000, 0,0,1));
        // 10:00 -> 09:59 after exactly 4 cycles, then reload mid-run.
        vecs.push_back(v(1,0,0, 8'h10,8'h00, 12'h010,12'h000, 0,0,0));
        vecs.push_back(v(0,1,0, 8'h00,8'h00, 12'h010,12'h000, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h010,12'h000, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h010,12'h000, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h010,12'h000, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h009,12'h059, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h009,12'h059, 1,0,0));
        vecs.push_back(v(1,0,0, 8'h03,8'h30, 12'h003,12'h030, 0,0,0));
        vecs.push_back(v(0,1,0, 8'h00,8'h00, 12'h003,12'h030, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h003,12'h030, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h003,12'h030, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h003,12'h030, 1,0,0));
        vecs.push_back(v(0,0,0, 8'h00,8'h00, 12'h003,12'h029, 1,0,0));
        // start+stop together: stop wins in RUN and in PAUSE.
        vecs.push_back(v(0,1,1, 8'h00,8'h00, 12'h003,12'h029, 0,0,0));
        vecs.push_back(v(0,1,0, 8'h00,8'h00, 12'h003,12'h029, 1,0,0));
        vecs.push_back(v(0,0,1, 8'h00,8'h00, 12'h003,12'h029, 0,0,0));
        vecs.push_back(v(0,1,1, 8'h00,8'h00, 12'h003,12'h029, 0,0,0));
        vecs.push_back(v(1,0,0, 8'h00,8'h7C, 12'h000,12'h059, 0,0,0));
        vecs.push_back(v(1,1,1, 8'h00,8'h00, 12'h000,12'h000, 0,0,0));

        // Reset held two cycles with load and start asserted.
        rst = 1'b1; load = 1'b1; start = 1'b1; stop = 1'b0; set_mins = 8'h12; set_secs = 8'h34;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 12'h000, 12'h000, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].smin, vecs[i].ssec);
            chk_all($sformatf("row%0d", i), vecs[i].emin, vecs[i].esec,
                    vecs[i].erun, vecs[i].edone, vecs[i].eexp);
        end

        // 01:02 countdown to expiry.
        step(1,0,0, 8'h01, 8'h02);
        step(0,1,0, 8'h00, 8'h00);
        chk("cd_running", 32'(running), 32'd1);
        repeat (4) step(0,0,0, 8'h00, 8'h00);
        chk("cd_4", 32'(secs), 32'h001);
        repeat (4) step(0,0,0, 8'h00, 8'h00);
        chk("cd_8", 32'(secs), 32'h000);
        repeat (4) step(0,0,0, 8'h00, 8'h00);
        chk("cd_12_mins", 32'(mins), 32'h000);
        chk("cd_12_secs", 32'(secs), 32'h059);
        cyc = 12;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            step(0,0,0, 8'h00, 8'h00);
            cyc++;
            if (done) seen = 1'b1;
        end
        chk("cd_done_seen", 32'(seen), 32'd1);
        chk("cd_done_cycle", 32'(cyc), 32'd248);
        chk_all("cd_at_done", 12'h000, 12'h000, 0, 1, 1);
        step(0,0,0, 8'h00, 8'h00);
        chk_all("cd_after_done", 12'h000, 12'h000, 0, 0, 1);
        step(0,1,0, 8'h00, 8'h00);
        chk_all("cd_start_ignored", 12'h000, 12'h000, 0, 0, 1);

        // Pause keeps the prescaler: first decrement 2 cycles after resume.
        step(1,0,0, 8'h00, 8'h05);
        step(0,1,0, 8'h00, 8'h00);
        step(0,0,0, 8'h00, 8'h00);
        step(0,0,0, 8'h00, 8'h00);
        step(0,0,1, 8'h00, 8'h00);
        chk_all("pause_enter", 12'h000, 12'h005, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0,0,0, 8'h00, 8'h00);
            chk($sformatf("pause_hold%0d", k), 32'(secs), 32'h005);
        end
        step(0,1,0, 8'h00, 8'h00);
        chk_all("resume", 12'h000, 12'h005, 1, 0, 0);
        step(0,0,0, 8'h00, 8'h00);
        chk("resume_1", 32'(secs), 32'h005);
        step(0,0,0, 8'h00, 8'h00);
        chk("resume_2", 32'(secs), 32'h004);

        // Reset mid-run, then start with 00:00 expires immediately.
        step(1,0,0, 8'h05, 8'h17);
        step(0,1,0, 8'h00, 8'h00);
        step(0,0,0, 8'h00, 8'h00);
        chk_all("pre_rst", 12'h005, 12'h017, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("mid_rst", 12'h000, 12'h000, 0, 0, 0);
        step(0,1,0, 8'h00, 8'h00);
        chk_all("rst_start", 12'h000, 12'h000, 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Minutes:seconds countdown timer that produces the packed-BCD `mins`/`secs` buses consumed by the team's 4-digit seven-segment display driver.
- It is the writer side of that display interface.
- Operator loads a start time, then starts, pauses and resumes it.
- Flags completion with a one-cycle `done` pulse and a sticky `expired` level.

Parameters:
- DIV, 100000000, clk cycles per one-second tick; minimum 2; the bench uses 4.
- PW, 27, prescaler width; must satisfy 2^PW >= DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- load  input  1  capture `set_mins`/`set_secs` and go to IDLE
- start  input  1  begin or resume counting
- stop  input  1  pause counting
- set_mins  input  8  BCD minutes to load: [7:4] tens, [3:0] units
- set_secs  input  8  BCD seconds to load: [7:4] tens, [3:0] units
- mins  output  12  BCD minutes for the display; [11:8] always 0
- secs  output  12  BCD seconds for the display; [11:8] always 0
- running  output  1  high in RUN
- done  output  1  one-cycle pulse on entry to EXPIRED
- expired  output  1  high in EXPIRED

Behaviour:
- Reset: state IDLE, mins=0, secs=0, prescaler=0, running=0, done=0, expired=0. Reset overrides all other inputs.
- All state is registered; outputs change on the clk edge after the causing input.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Input priority each cycle: rst > load > stop > start.
- load (any state): go to IDLE and clear the prescaler. Loaded values are clamped per digit:
  - minute digits > 9 become 9;
  - seconds tens > 5 becomes 5;
  - seconds units > 9 becomes 9.
  - Example: set_secs=8'h7C loads 8'h59.
- start:
  - IDLE: if the loaded time is 00:00, go to EXPIRED (done pulses). Otherwise go to RUN with the prescaler cleared.
  - PAUSE: go to RUN with the prescaler kept.
  - RUN and EXPIRED: ignored.
- stop:
  - RUN: go to PAUSE; the prescaler is frozen.
  - Any other state: ignored.
- Simultaneous stop and start: stop wins, so from RUN go to PAUSE, and from PAUSE stay in PAUSE.
- Prescaler (RUN only):
  - Increments each cycle.
  - On the cycle it equals DIV-1, it wraps to 0 and asserts an internal tick.
  - The first decrement therefore occurs DIV cycles after the start edge.
- On tick, BCD decrement with borrow:
  - secs units > 0: units-1.
  - secs units = 0, tens > 0: units=9, tens-1.
  - secs = 00 and mins > 0: secs=59, mins decrements with the same units/tens borrow rule.
  - Example: 10:00 becomes 09:59.
- Expiry: when a tick produces 00:00, the same edge sets state EXPIRED, done=1 for exactly one cycle, and expired=1.
  - The 00:00 value is visible in the same cycle done is high.
- EXPIRED: outputs hold 00:00; only load or rst leaves it.
- Maximum loaded value is 99:59; values never underflow below 00:00.
- Upper nibbles [11:8] of mins and secs are constant 0.
- running = (state==RUN).

Test Plan:
- rst held 2 cycles with load=1 and start=1 -> mins=12'h000, secs=12'h000, running=0, done=0, expired=0.
- DIV=4; load 01:02, start -> running=1.
  - secs reads 01 at 4 cycles after the start edge, 00 at 8 cycles, and mins=00/secs=59 at 12 cycles.
  - Continue to 00:00: done is high exactly one cycle, expired=1 afterwards, and further start is ignored.
- DIV=4; load 00:05, start, 2 cycles, stop for 10 cycles, start -> no change while paused.
  - First decrement to 04 occurs 2 cycles after resume (prescaler retained).
  - A cycle with start and stop both high during RUN enters PAUSE.
- load 8'h9F / 8'hAB -> mins=12'h099, secs=12'h059.
  - load 00:00 then start -> EXPIRED on the next edge, done=1 for one cycle.
- DIV=4; load 10:00, run 1 tick -> mins=09, secs=59.
  - load 03:30 while in RUN -> IDLE, running=0, outputs 03:30, prescaler cleared.
  - start -> first decrement after 4 cycles.
- rst asserted mid-RUN at 05:17 -> next edge all outputs at reset values, state IDLE; start without load -> immediately EXPIRED.
